// File: rtl/falafel_pkg.sv
// falafel_pkg: shared widths and payload type for the falafel response path
package falafel_pkg;
    localparam int DATA_W      = 32;
    localparam int MSG_ID_SIZE = 2;
    typedef logic [DATA_W-1:0] word_t;
endpackage

// File: rtl/falafel_fifo.sv
// falafel_fifo: synchronous FIFO with wrap-bit pointers
// Ports: clk_i/rst_ni clock and async active-low reset; push_i/data_i write side
// (ignored when full); pop_i read side (ignored when empty); data_o head entry;
// full_o/empty_o derived only from registered pointers.
module falafel_fifo #(
    parameter int NUM_ENTRIES = 4,
    parameter int DATA_W      = 32
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              push_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              pop_i,
    output logic [DATA_W-1:0] data_o,
    output logic              full_o,
    output logic              empty_o
);
    localparam int AW = $clog2(NUM_ENTRIES);
    if (NUM_ENTRIES < 2 || (NUM_ENTRIES & (NUM_ENTRIES - 1)) != 0) begin : g_bad_depth
        $error("falafel_fifo: NUM_ENTRIES must be a power of two >= 2");
    end
    logic [DATA_W-1:0] mem [NUM_ENTRIES];
    logic [AW:0]       wr_ptr, rd_ptr;
    logic              do_push, do_pop;
    // The extra MSB is a wrap bit: equal indices with differing wrap bits means full.
    assign full_o  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty_o = wr_ptr == rd_ptr;
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;
    assign data_o  = mem[rd_ptr[AW-1:0]];
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            wr_ptr <= wr_ptr + (AW+1)'(do_push);
            rd_ptr <= rd_ptr + (AW+1)'(do_pop);
        end
    end
    always_ff @(posedge clk_i) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= data_i;
    end
endmodule

// File: rtl/falafel_resp_router.sv
// falafel_resp_router: routes core responses by message ID into per-channel FIFOs
// Ports: clk_i/rst_ni clock and async active-low reset; in_val_i/in_rdy_o/in_id_i/
// in_data_i single input stream; out_val_o/out_rdy_i/out_data_o one stream per
// channel (data flattened, channel c at [c*DATA_W +: DATA_W]); drop_cnt_o
// saturating count of responses discarded for an out-of-range ID.
module falafel_resp_router
    import falafel_pkg::*;
#(
    parameter int NUM_CHANNELS = 2,
    parameter int DEPTH        = 4,
    parameter int CNT_W        = 16
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic                           in_val_i,
    output logic                           in_rdy_o,
    input  logic [MSG_ID_SIZE-1:0]         in_id_i,
    input  logic [DATA_W-1:0]              in_data_i,
    output logic [NUM_CHANNELS-1:0]        out_val_o,
    input  logic [NUM_CHANNELS-1:0]        out_rdy_i,
    output logic [NUM_CHANNELS*DATA_W-1:0] out_data_o,
    output logic [CNT_W-1:0]               drop_cnt_o
);
    if (NUM_CHANNELS < 1 || NUM_CHANNELS > 2**MSG_ID_SIZE) begin : g_bad_channels
        $error("falafel_resp_router: NUM_CHANNELS out of range");
    end
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("falafel_resp_router: DEPTH must be a power of two >= 2");
    end
    logic [NUM_CHANNELS-1:0] sel, push, full, empty;
    word_t                   head [NUM_CHANNELS];
    logic                    oor, drop;
    assign oor  = 32'(in_id_i) >= NUM_CHANNELS;
    assign drop = in_val_i & oor;
    // Ready depends only on registered FIFO state, so out_rdy_i never reaches in_rdy_o.
    assign in_rdy_o = oor | |(sel & ~full);
    for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_ch
        assign sel[c]  = in_id_i == MSG_ID_SIZE'(c);
        assign push[c] = in_val_i & sel[c] & ~full[c];
        falafel_fifo #(
            .NUM_ENTRIES(DEPTH),
            .DATA_W     (DATA_W)
        ) u_fifo (
            .clk_i  (clk_i),
            .rst_ni (rst_ni),
            .push_i (push[c]),
            .data_i (in_data_i),
            .pop_i  (out_rdy_i[c]),
            .data_o (head[c]),
            .full_o (full[c]),
            .empty_o(empty[c])
        );
        assign out_val_o[c] = ~empty[c];
        assign out_data_o[c*DATA_W +: DATA_W] = empty[c] ? '0 : head[c];
    end
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) drop_cnt_o <= '0;
        else if (drop && !(&drop_cnt_o)) drop_cnt_o <= drop_cnt_o + 1'b1;
    end
endmodule

// File: doc/falafel_resp_router.md
FALAFEL_RESP_ROUTER -- requirements
Module: falafel_resp_router

Interface
REQ-001 SHALL have parameter NUM_CHANNELS, default 2, the number of response channels (1..2**MSG_ID_SIZE).
REQ-002 SHALL have parameter DEPTH, default 4, the entries per channel buffer (power of two, >=2).
REQ-003 SHALL have parameter CNT_W, default 16, the width of the drop counter.
REQ-004 clk_i  input  1  single clock; all state updates on its rising edge.
REQ-005 rst_ni  input  1  reset, asynchronous, active-low.
REQ-006 in_val_i  input  1  response valid from core side.
REQ-007 in_rdy_o  output  1  router accepts the response.
REQ-008 in_id_i  input  MSG_ID_SIZE  message ID; selects the destination channel.
REQ-009 in_data_i  input  DATA_W  response payload (pointer).
REQ-010 out_val_o  output  [NUM_CHANNELS] x 1  channel response valid.
REQ-011 out_rdy_i  input  [NUM_CHANNELS] x 1  channel consumer ready.
REQ-012 out_data_o  output  [NUM_CHANNELS] x DATA_W  channel response payload.
REQ-013 drop_cnt_o  output  CNT_W  count of responses dropped for an out-of-range ID.

Function
REQ-014 Target channel = in_id_i; ID >= NUM_CHANNELS is out-of-range.
REQ-015 in_rdy_o = 1 if ID out-of-range, else NOT full(target channel); no combinational path from out_rdy_i to in_rdy_o.
REQ-016 Transfer on in_val_i & in_rdy_o; in-range payload pushed to target channel tail.
REQ-017 Out-of-range transfer: payload discarded, drop_cnt_o +1 next cycle, saturating at 2**CNT_W-1.
REQ-018 Channel pop on out_val_o[c] & out_rdy_i[c]; channels pop independently and concurrently.
REQ-019 out_val_o[c] = channel c non-empty; out_data_o[c] = head entry when valid, all-zero when empty.
REQ-020 Latency: payload accepted in cycle N appears on out_val_o/out_data_o in cycle N+1; no same-cycle bypass.
REQ-021 Per-channel order SHALL be FIFO; no ordering relation across channels.
REQ-022 Full channel: in_rdy_o low for that ID even if the same-cycle pop frees a slot; a pushed entry is never lost or overwritten.
REQ-023 Simultaneous push and pop on a non-full, non-empty channel: occupancy unchanged, both take effect.
REQ-024 Pointer wrap-around at DEPTH SHALL be seamless; full/empty distinguished by a wrap bit.
REQ-025 Other channels' out_val/out_data SHALL be unaffected by traffic to a given channel.
REQ-026 Elaboration SHALL fail if NUM_CHANNELS > 2**MSG_ID_SIZE, NUM_CHANNELS < 1, or DEPTH not a power of two >= 2.

Reset
REQ-027 On rst_ni low (asynchronous): all channels empty, out_val_o all 0, out_data_o all 0, drop_cnt_o 0.
REQ-028 in_rdy_o SHALL be 1 during and immediately after reset; reset mid-transfer discards all buffered and in-flight responses.

Structure
REQ-029 DATA_W, MSG_ID_SIZE, word_t from falafel_pkg; no new package types required.
REQ-030 One falafel_fifo instance per channel (NUM_ENTRIES = DEPTH, DATA_W = DATA_W) via generate loop; routing, zero-masking and drop counter in this module.

Verification
REQ-031 Reset; push ID=0 data=0x1000 -> out_val_o[0]=1, out_data_o[0]=0x1000 next cycle; out_val_o[1]=0.
REQ-032 DEPTH=4, out_rdy_i[1]=0, push ID=1 x5 -> 4 accepted, in_rdy_o=0 on 5th; ID=0 pushes still accepted that cycle.
REQ-033 Channel 1 full, assert out_rdy_i[1] while in_val_i ID=1 -> pop occurs, push refused that cycle, accepted next; order 0xA,0xB,0xC,0xD,0xE preserved.
REQ-034 NUM_CHANNELS=2, push ID=3 x3 -> in_rdy_o=1, no out_val_o, drop_cnt_o=3; CNT_W=2, 5 drops -> drop_cnt_o=3.
REQ-035 Continuous push/pop on channel 0 for 10 entries (wraps pointer twice) -> occupancy stays 1, data in order, no loss.
REQ-036 Assert rst_ni low with 3 entries in channel 0 -> out_val_o[0]=0 and out_data_o[0]=0 asynchronously, drop_cnt_o=0.
